zbritesi_serik: RTL

Bit-serial subtractor computing `A - B - BIN` on WIDTH-bit operands, one bit per clock, LSB first. It is built around the same single-bit cell equations as the team's 1-bit full adder, with B inverted and the carry reinterpreted as a borrow. It trades latency for area and sits beside the ripple adders in the arithmetic datapath, driven by a START/DONE handshake. Outputs are the registered difference, the final borrow, a signed-overflow flag and a zero flag.

---
 rtl/zbritesi_serik_if.sv | 26 ++
 rtl/zbritesi_serik.sv | 111 +++++++++++
 2 files changed

// File: rtl/zbritesi_serik_if.sv
// Start/done handshake bundle for the bit-serial subtractor.
// Operands flow master -> slave, results flow back.
interface zbritesi_serik_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;
  logic             zero;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout, ovf, zero
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout, ovf, zero
  );
endinterface

// File: rtl/zbritesi_serik.sv
// Bit-serial subtractor: a - b - bin, one bit per clock, LSB first.
// Full-adder cell with b inverted; carry is read as a borrow.
module zbritesi_serik #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  zbritesi_serik_if.slave   bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh, b_sh, r_sh;
  logic             borrow;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q, ovf_q, zero_q;

  logic             load, step, fin;
  logic             ab, bb, d, cn;
  logic [WIDTH-1:0] res;

  assign ab  = a_sh[0];
  assign bb  = b_sh[0];
  assign d   = ab ^ bb ^ borrow;
  assign cn  = (~ab & bb) | (~ab & borrow) | (bb & borrow);
  assign res = {d, r_sh[WIDTH-1:1]};

  always_comb begin
    state_n = state;
    load    = 1'b0;
    step    = 1'b0;
    fin     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bus.start) begin
          state_n = ST_RUN;
          load    = 1'b1;
        end
      end
      ST_RUN: begin
        step = 1'b1;
        if (cnt == CW'(WIDTH - 1)) begin
          state_n = ST_DONE;
          fin     = 1'b1;
        end
      end
      ST_DONE: begin
        if (bus.start) begin
          state_n = ST_RUN;
          load    = 1'b1;
        end else begin
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      a_sh   <= '0;
      b_sh   <= '0;
      r_sh   <= '0;
      borrow <= 1'b0;
      diff_q <= '0;
      bout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      if (load) begin
        a_sh   <= bus.a;
        b_sh   <= bus.b;
        borrow <= bus.bin;
        cnt    <= '0;
      end else if (step) begin
        a_sh   <= a_sh >> 1;
        b_sh   <= b_sh >> 1;
        borrow <= cn;
        r_sh   <= res;
        cnt    <= cnt + CW'(1);
      end
      // On the last bit the shifters hold the operand sign bits in [0].
      if (fin) begin
        diff_q <= res;
        bout_q <= cn;
        ovf_q  <= (ab ^ bb) & (d ^ ab);
        zero_q <= (res == '0);
      end
    end
  end

  assign bus.busy = (state == ST_RUN);
  assign bus.done = (state == ST_DONE);
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
  assign bus.ovf  = ovf_q;
  assign bus.zero = zero_q;
endmodule
